decoder_scan_nto2n: RTL and testbench
=====================================

Name: decoder_scan_nto2n

Overview:
- Parametrised binary-to-one-hot decoder with registered, active-low outputs and an active-high enable.
- Generalises the 3-to-8 decoder to SEL_W select bits.
- Adds a sequential scan mode that walks the active output from a start index to the top index, holding each for a programmable dwell time.
- Used as a row/chip-select driver and for strobing banks of loads.

Parameters:
- SEL_W, 3, select width; legal 1..8.
- OUT_N, 2**SEL_W, number of outputs; must equal 2**SEL_W (elaboration error otherwise).
- DWELL_W, 4, width of dwell counter and dwell input.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  active-high enable; low forces all outputs inactive.
- mode  input  1  0 = direct decode, 1 = scan; sampled only when start is accepted.
- start  input  1  single-cycle request; in scan mode begins a scan, ignored in direct mode.
- sel_in  input  SEL_W  direct-mode select / scan start index.
- dwell  input  DWELL_W  cycles each output stays active in scan; 0 treated as 1; sampled at start.
- y_n  output  OUT_N  active-low decoded outputs; at most one bit low.
- sel_out  output  SEL_W  index currently driven low; 0 when none active.
- busy  output  1  high while a scan is in progress.
- scan_done  output  1  one-cycle pulse after the last output of a scan completes its dwell.

Behaviour:
- Reset, asynchronous, while rst=1:
  - y_n = all ones, sel_out = 0, busy = 0, scan_done = 0.
  - State IDLE; internal counters cleared.
- States: IDLE, SCAN.
- IDLE, direct decode (any mode, start ignored when mode=0):
  - Registered, 1-cycle latency.
  - If en=1: y_n <= ~(1 << sel_in), sel_out <= sel_in.
  - Otherwise: y_n <= all ones, sel_out <= 0.
- IDLE, start=1 & mode=1 & en=1:
  - Latch idx = sel_in and dwell_l = max(dwell, 1).
  - Go to SCAN. Next cycle: y_n = ~(1 << idx), busy = 1, dwell counter = 1.
- SCAN:
  - Each cycle: if dwell counter == dwell_l, then either:
    - idx == OUT_N-1: y_n <= all ones, sel_out <= 0, busy <= 0, scan_done <= 1 for one cycle, go to IDLE; or
    - otherwise: idx <= idx+1, dwell counter <= 1.
  - Else dwell counter increments.
  - Output index k is low for exactly dwell_l cycles.
  - A scan from index s lasts (OUT_N-s)*dwell_l cycles.
- Abort: en=0 during SCAN:
  - Next cycle y_n = all ones, sel_out = 0, busy = 0, state IDLE.
  - No scan_done pulse.
- Ignored inputs:
  - start during SCAN is ignored; no restart, no queueing.
  - mode, sel_in and dwell changes during SCAN have no effect.
- start with en=0: ignored.
- start in the same cycle scan_done is asserted: accepted, since the FSM is already IDLE.
- Index never wraps: scan terminates at OUT_N-1.
  - Scan starting at OUT_N-1 drives one output for dwell_l cycles, then pulses scan_done.
- Reset mid-scan: immediate return to reset values; no scan_done.
- Invariant, checked by an assertion: y_n has zero or one bit low, never more.

Optional Feature:
- Macro DECODER_SCAN_DIR_EN.
- When defined:
  - Adds input port dir (1 bit), sampled at start.
  - dir=1 scans downward: idx decrements and termination index is 0.
  - dir=0 behaves as the base scan.
- When undefined:
  - No dir port; scan is upward only.
  - Logic is identical to dir=0.

Decomposition:
- Shared package decoder_pkg holds:
  - state enum (IDLE, SCAN);
  - function onehot_n(sel) returning the active-low vector;
  - localparam DEFAULT_SEL_W.
- One sub-module, decoder_dwell_cnt: loadable dwell counter with terminal-count output.
- Decode and FSM stay in the top module.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> y_n=8'hFF, busy=0, sel_out=0 immediately, with no clock edge needed.
- Direct mode, SEL_W=3, en=1, sel_in=0..7 one per cycle -> y_n the cycle after each is FE, FD, FB, F7, EF, DF, BF, 7F; en=0 -> FF.
- Scan, sel_in=5, dwell=2:
  - Expected y_n = DF,DF,BF,BF,7F,7F, then FF with scan_done=1 for one cycle.
  - busy high for exactly 6 cycles.
- Scan, sel_in=2, dwell=0: each output low for 1 cycle; scan_done after 6 cycles.
- Abort and ignored start:
  - Scan sel_in=0, dwell=3; drop en at cycle 4 -> y_n=FF next cycle, busy=0, no scan_done.
  - start pulsed mid-scan -> trace unchanged.
- DECODER_SCAN_DIR_EN, dir=1, sel_in=2, dwell=1 -> y_n = FB, FD, FE, then FF with scan_done pulse.

Source files
------------

// File: rtl/decoder_scan_nto2n_pkg.sv
// ----------------------------------------------------------------------------
// decoder_pkg
//
// Purpose:
//   Shared definitions for the decoder_scan_nto2n block: the FSM state
//   enumeration, the default select width and a helper that builds an
//   active-low one-hot vector from a binary index.
//
// Contents:
//   DEFAULT_SEL_W  default select width of the decoder (3 -> 8 outputs)
//   MAX_OUT        widest output vector the helper can produce (SEL_W <= 8)
//   state_e        IDLE / SCAN
//   onehot_n(sel)  returns ~(1 << sel) at MAX_OUT bits; callers size-cast it
//                  down to their own output width
// ----------------------------------------------------------------------------
package decoder_pkg;

  localparam int DEFAULT_SEL_W = 3;
  localparam int MAX_OUT       = 256;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Active-low one-hot: exactly bit 'sel' is zero.
  function automatic logic [MAX_OUT-1:0] onehot_n(input logic [7:0] sel);
    onehot_n = ~(MAX_OUT'(1) << sel);
  endfunction

endpackage

// File: rtl/decoder_scan_nto2n_if.sv
// ----------------------------------------------------------------------------
// decoder_scan_nto2n_if
//
// Purpose:
//   Bundles the control inputs and decoded outputs of decoder_scan_nto2n.
//   The master modport drives the controls (the user of the decoder), the
//   slave modport is taken by the decoder itself.
//
// Signals:
//   en         active-high enable; low forces all outputs inactive
//   mode       0 = direct decode, 1 = scan (sampled when start is accepted)
//   start      single-cycle scan request
//   sel_in     direct select / scan start index
//   dwell      cycles each scan output stays active (0 behaves as 1)
//   dir        scan direction, 1 = downward (only with DECODER_SCAN_DIR_EN)
//   y_n        active-low decoded outputs, at most one bit low
//   sel_out    index currently driven low, 0 when none active
//   busy       high while a scan is running
//   scan_done  one-cycle pulse when a scan completes normally
//
// Optional feature macro: DECODER_SCAN_DIR_EN (adds dir).
// ----------------------------------------------------------------------------
interface decoder_scan_nto2n_if #(
  parameter int SEL_W   = 3,
  parameter int OUT_N   = 2**SEL_W,
  parameter int DWELL_W = 4
);

  logic               en;
  logic               mode;
  logic               start;
  logic [SEL_W-1:0]   sel_in;
  logic [DWELL_W-1:0] dwell;
`ifdef DECODER_SCAN_DIR_EN
  logic               dir;
`endif
  logic [OUT_N-1:0]   y_n;
  logic [SEL_W-1:0]   sel_out;
  logic               busy;
  logic               scan_done;

  modport master (
`ifdef DECODER_SCAN_DIR_EN
    output dir,
`endif
    output en, mode, start, sel_in, dwell,
    input  y_n, sel_out, busy, scan_done
  );

  modport slave (
`ifdef DECODER_SCAN_DIR_EN
    input  dir,
`endif
    input  en, mode, start, sel_in, dwell,
    output y_n, sel_out, busy, scan_done
  );

endinterface

// File: rtl/decoder_scan_nto2n_dwell_cnt.sv
// ----------------------------------------------------------------------------
// decoder_dwell_cnt
//
// Purpose:
//   Loadable dwell counter for the scan sequencer. A load captures the dwell
//   limit (0 is promoted to 1) and restarts the count at 1. While advancing
//   the count climbs to the limit and then wraps back to 1, so 'tc' is high
//   on the last cycle of every dwell window.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   load      restart counting with limit = max(load_val, 1)
//   load_val  requested dwell length
//   advance   step the count (wraps to 1 after reaching the limit)
//   clear     return count to 0 (scan finished or aborted)
//   tc        count equals the limit
//
// Priority: clear > load > advance.
// ----------------------------------------------------------------------------
module decoder_dwell_cnt #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               advance,
  input  logic               clear,
  output logic               tc
);

  logic [DWELL_W-1:0] cnt_reg;
  logic [DWELL_W-1:0] lim_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      lim_reg <= DWELL_W'(1);
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= DWELL_W'(1);
      lim_reg <= (load_val == '0) ? DWELL_W'(1) : load_val;
    end else if (advance) begin
      cnt_reg <= tc ? DWELL_W'(1) : cnt_reg + DWELL_W'(1);
    end
  end

  assign tc = (cnt_reg == lim_reg);

endmodule

// File: rtl/decoder_scan_nto2n.sv
// ----------------------------------------------------------------------------
// decoder_scan_nto2n
//
// Purpose:
//   Binary-to-one-hot decoder with registered active-low outputs. In IDLE it
//   decodes sel_in directly (one cycle latency). A start with mode=1 runs a
//   scan that walks the active output from sel_in to the end index, holding
//   each output low for max(dwell,1) cycles, then pulses scan_done.
//   Dropping en during a scan aborts it without a scan_done pulse.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   decoder_scan_nto2n_if.slave (controls in, y_n/sel_out/busy/
//         scan_done out)
//
// Parameters:
//   SEL_W    select width, 1..8
//   OUT_N    number of outputs, must equal 2**SEL_W
//   DWELL_W  width of dwell input/counter
//
// Optional feature macro: DECODER_SCAN_DIR_EN
//   When defined, bus.dir is sampled at start; dir=1 scans downward and
//   terminates at index 0. Without it the scan is upward only.
// ----------------------------------------------------------------------------
module decoder_scan_nto2n
  import decoder_pkg::*;
#(
  parameter int SEL_W   = DEFAULT_SEL_W,
  parameter int OUT_N   = 2**SEL_W,
  parameter int DWELL_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  decoder_scan_nto2n_if.slave bus
);

  // Elaboration-time parameter checks.
  generate
    if (SEL_W < 1 || SEL_W > 8) begin : g_bad_sel_w
      $error("decoder_scan_nto2n: SEL_W must be in 1..8");
    end
    if (OUT_N != 2**SEL_W) begin : g_bad_out_n
      $error("decoder_scan_nto2n: OUT_N must equal 2**SEL_W");
    end
  endgenerate

  localparam logic [0:0]       ST_IDLE  = IDLE;
  localparam logic [0:0]       ST_SCAN  = SCAN;
  localparam logic [OUT_N-1:0] ALL_OFF  = '1;
  localparam logic [SEL_W-1:0] TOP_IDX  = SEL_W'(OUT_N - 1);

  logic [0:0]       state_reg,   state_next;
  logic [SEL_W-1:0] idx_reg,     idx_next;
  logic [OUT_N-1:0] y_reg,       y_next;
  logic [SEL_W-1:0] sel_out_reg, sel_out_next;
  logic             busy_reg,    busy_next;
  logic             done_reg,    done_next;

  logic             cnt_load;
  logic             cnt_adv;
  logic             cnt_clear;
  logic             cnt_tc;

  logic             scan_down;
  logic [SEL_W-1:0] end_idx;
  logic [SEL_W-1:0] step_idx;
  logic [OUT_N-1:0] dec_sel_in;
  logic [OUT_N-1:0] dec_step;

`ifdef DECODER_SCAN_DIR_EN
  logic dir_reg, dir_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_reg <= 1'b0;
    end else begin
      dir_reg <= dir_next;
    end
  end

  // Direction is captured only when a scan is accepted.
  always_comb begin
    dir_next = dir_reg;
    if (state_reg == ST_IDLE && bus.en && bus.start && bus.mode) begin
      dir_next = bus.dir;
    end
  end

  assign scan_down = dir_reg;
`else
  assign scan_down = 1'b0;
`endif

  // Scan terminates at the far end in the travel direction; never wraps.
  assign end_idx  = scan_down ? '0 : TOP_IDX;
  assign step_idx = scan_down ? idx_reg - SEL_W'(1) : idx_reg + SEL_W'(1);

  assign dec_sel_in = OUT_N'(onehot_n(8'(bus.sel_in)));
  assign dec_step   = OUT_N'(onehot_n(8'(step_idx)));

  decoder_dwell_cnt #(
    .DWELL_W (DWELL_W)
  ) u_dwell_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (bus.dwell),
    .advance  (cnt_adv),
    .clear    (cnt_clear),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    y_next       = y_reg;
    sel_out_next = sel_out_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    cnt_load     = 1'b0;
    cnt_adv      = 1'b0;
    cnt_clear    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Direct decode runs in IDLE regardless of mode; an accepted scan
        // start drives the same pattern, so the first scan output lines up.
        if (bus.en) begin
          y_next       = dec_sel_in;
          sel_out_next = bus.sel_in;
        end else begin
          y_next       = ALL_OFF;
          sel_out_next = '0;
        end
        busy_next = 1'b0;

        if (bus.en && bus.start && bus.mode) begin
          state_next = ST_SCAN;
          idx_next   = bus.sel_in;
          busy_next  = 1'b1;
          cnt_load   = 1'b1;
        end
      end

      ST_SCAN: begin
        if (!bus.en) begin
          // Abort: back to idle with outputs off and no completion pulse.
          state_next   = ST_IDLE;
          y_next       = ALL_OFF;
          sel_out_next = '0;
          busy_next    = 1'b0;
          cnt_clear    = 1'b1;
        end else begin
          cnt_adv = 1'b1;
          if (cnt_tc) begin
            if (idx_reg == end_idx) begin
              state_next   = ST_IDLE;
              y_next       = ALL_OFF;
              sel_out_next = '0;
              busy_next    = 1'b0;
              done_next    = 1'b1;
              cnt_clear    = 1'b1;
            end else begin
              idx_next     = step_idx;
              y_next       = dec_step;
              sel_out_next = step_idx;
            end
          end
        end
      end

      default: begin
        state_next   = ST_IDLE;
        y_next       = ALL_OFF;
        sel_out_next = '0;
        busy_next    = 1'b0;
        cnt_clear    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      idx_reg     <= '0;
      y_reg       <= ALL_OFF;
      sel_out_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      y_reg       <= y_next;
      sel_out_reg <= sel_out_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  assign bus.y_n       = y_reg;
  assign bus.sel_out   = sel_out_reg;
  assign bus.busy      = busy_reg;
  assign bus.scan_done = done_reg;

  // At most one output may ever be active.
  a_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(~y_reg));

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
module tb_decoder_scan_nto2n;

  localparam int SEL_W   = 3;
  localparam int OUT_N   = 8;
  localparam int DWELL_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoder_scan_nto2n_if #(.SEL_W(SEL_W), .OUT_N(OUT_N), .DWELL_W(DWELL_W)) bus ();

  decoder_scan_nto2n #(.SEL_W(SEL_W), .OUT_N(OUT_N), .DWELL_W(DWELL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A scan is expanded into its full output schedule at the moment it is
  // accepted; each clock consumes one entry. en=0 throws the schedule away.
  typedef struct packed {
    logic [OUT_N-1:0] y;
    logic [SEL_W-1:0] s;
    logic             b;
    logic             d;
  } exp_t;

  exp_t sched[$];
  exp_t exp_cur;
  bit   chk_on = 0;

  function automatic exp_t mk(input bit act, input int k, input bit b, input bit d);
    exp_t e;
    e.y = '1;
    e.s = '0;
    if (act) begin
      e.y[k] = 1'b0;
      e.s    = SEL_W'(k);
    end
    e.b = b;
    e.d = d;
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    int  s, d, n;
    bit  down;
    if (rst) begin
      sched.delete();
      exp_cur = mk(0, 0, 0, 0);
    end else if (sched.size() != 0) begin
      if (!bus.en) begin
        sched.delete();
        exp_cur = mk(0, 0, 0, 0);
      end else begin
        exp_cur = sched.pop_front();
      end
    end else if (bus.en && bus.start && bus.mode) begin
      s    = int'(bus.sel_in);
      d    = (bus.dwell == 0) ? 1 : int'(bus.dwell);
      down = 0;
`ifdef DECODER_SCAN_DIR_EN
      down = bus.dir;
`endif
      n = down ? s + 1 : OUT_N - s;
      for (int j = 0; j < n; j++)
        for (int r = 0; r < d; r++)
          sched.push_back(mk(1, down ? s - j : s + j, 1, 0));
      sched.push_back(mk(0, 0, 0, 1));
      $display("scan start idx=%0d dwell=%0d down=%0d len=%0d", s, d, down, n * d);
      exp_cur = sched.pop_front();
    end else if (bus.en) begin
      exp_cur = mk(1, int'(bus.sel_in), 0, 0);
    end else begin
      exp_cur = mk(0, 0, 0, 0);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("y_n",       64'(bus.y_n),       64'(exp_cur.y));
      check("sel_out",   64'(bus.sel_out),   64'(exp_cur.s));
      check("busy",      64'(bus.busy),      64'(exp_cur.b));
      check("scan_done", 64'(bus.scan_done), 64'(exp_cur.d));
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] lit_direct [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] lit_scan5  [7] = '{8'hDF, 8'hDF, 8'hBF, 8'hBF, 8'h7F, 8'h7F, 8'hFF};
`ifdef DECODER_SCAN_DIR_EN
  logic [7:0] lit_down2  [4] = '{8'hFB, 8'hFD, 8'hFE, 8'hFF};
`endif

  task automatic start_scan(input int s, input int d);
    bus.en     = 1'b1;
    bus.mode   = 1'b1;
    bus.start  = 1'b1;
    bus.sel_in = SEL_W'(s);
    bus.dwell  = DWELL_W'(d);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.mode   = 1'b0;
  endtask

  initial begin
    int         busy_cnt;
    int         done_cnt;
    logic [7:0] want;

    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.mode   = 1'b0;
    bus.start  = 1'b0;
    bus.sel_in = '0;
    bus.dwell  = '0;
`ifdef DECODER_SCAN_DIR_EN
    bus.dir    = 1'b0;
`endif
    exp_cur    = mk(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("reset_y_n",  64'(bus.y_n),  64'h0FF);
    check("reset_busy", 64'(bus.busy), 64'h0);
    rst    = 1'b0;
    chk_on = 1;

    // Direct decode, one select per cycle.
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.sel_in = SEL_W'(i);
      @(negedge clk);
      check("direct_lit", 64'(bus.y_n), 64'(lit_direct[i]));
      $display("direct sel=%0d y_n=%0h", i, bus.y_n);
    end
    bus.en = 1'b0;
    @(negedge clk);
    check("direct_en0", 64'(bus.y_n), 64'h0FF);

    // Scan from 5, dwell 2; repeated with a mid-scan start and input churn.
    for (int pass = 0; pass < 2; pass++) begin
      start_scan(5, 2);
      busy_cnt = 0;
      for (int i = 0; i < 7; i++) begin
        check("scan5_y_n",  64'(bus.y_n),       64'(lit_scan5[i]));
        check("scan5_done", 64'(bus.scan_done), 64'(i == 6));
        if (bus.busy) busy_cnt++;
        if (pass == 1 && i == 2) begin
          bus.start  = 1'b1;
          bus.mode   = 1'b1;
          bus.sel_in = '0;
          bus.dwell  = DWELL_W'(7);
        end else begin
          bus.start  = 1'b0;
          bus.mode   = 1'b0;
        end
        @(negedge clk);
      end
      check("scan5_busy_cycles", 64'(busy_cnt), 64'd6);
      check("scan5_done_clear",  64'(bus.scan_done), 64'h0);
      $display("scan5 pass=%0d busy_cycles=%0d", pass, busy_cnt);
    end

    // Scan from 2 with dwell 0 (treated as 1).
    start_scan(2, 0);
    busy_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      want = (i < 6) ? ~(8'h01 << (2 + i)) : 8'hFF;
      check("scan2_y_n",  64'(bus.y_n),       64'(want));
      check("scan2_done", 64'(bus.scan_done), 64'(i == 6));
      if (bus.busy) busy_cnt++;
      @(negedge clk);
    end
    check("scan2_busy_cycles", 64'(busy_cnt), 64'd6);

    // Abort: scan from 0, dwell 3, en dropped after 4 busy cycles.
    start_scan(0, 3);
    repeat (3) @(negedge clk);
    check("abort_pre_busy", 64'(bus.busy), 64'h1);
    bus.en = 1'b0;
    @(negedge clk);
    check("abort_y_n",  64'(bus.y_n),  64'h0FF);
    check("abort_busy", 64'(bus.busy), 64'h0);
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.scan_done) done_cnt++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    $display("abort done_pulses=%0d", done_cnt);

`ifdef DECODER_SCAN_DIR_EN
    bus.dir = 1'b1;
    start_scan(2, 1);
    for (int i = 0; i < 4; i++) begin
      check("down_y_n",  64'(bus.y_n),       64'(lit_down2[i]));
      check("down_done", 64'(bus.scan_done), 64'(i == 3));
      @(negedge clk);
    end
    bus.dir = 1'b0;
`endif

    // Asynchronous reset mid-scan, checked before any clock edge.
    start_scan(1, 4);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_y_n",     64'(bus.y_n),       64'h0FF);
    check("async_rst_busy",    64'(bus.busy),      64'h0);
    check("async_rst_sel_out", 64'(bus.sel_out),   64'h0);
    check("async_rst_done",    64'(bus.scan_done), 64'h0);
    $display("async reset y_n=%0h busy=%0d", bus.y_n, bus.busy);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      bus.en     = ($urandom_range(0, 19) != 0);
      bus.mode   = 1'($urandom_range(0, 1));
      bus.start  = ($urandom_range(0, 3) == 0);
      bus.sel_in = SEL_W'($urandom_range(0, OUT_N - 1));
      bus.dwell  = DWELL_W'($urandom_range(0, 3));
`ifdef DECODER_SCAN_DIR_EN
      bus.dir    = 1'($urandom_range(0, 1));
`endif
      @(negedge clk);
    end

    chk_on = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
